// File: rtl/serdes_tx_sched.sv
// Round-robin scheduler feeding one word at a time, MSB-first, into a 1-bit deserializer lane.
// Checks that the word-ready strobe comes back exactly one cycle after the last bit.
module serdes_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int GAP     = 1,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     ser_data,
  output logic                     ser_val,
  input  logic                     des_rdy,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     word_done,
  output logic                     sync_err,
  input  logic                     err_clr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_GAP = 4'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK, ST_GAP} state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] shreg;
  logic [IDW-1:0]   win;
  logic             found;
  logic             err_set;
  int               idx;

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (found) next_state = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == LAST_BIT) next_state = ST_CHECK;
      ST_CHECK: next_state = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == LAST_GAP) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The strobe is only legal in CHECK; missing there or present elsewhere is a framing error.
  assign err_set   = (state == ST_CHECK) ? !des_rdy : des_rdy;
  assign req_ready = (!rst && state == ST_IDLE && found) ? (NUM_REQ'(1) << win) : '0;
  assign ser_val   = (state == ST_SHIFT);
  assign ser_data  = ser_val & shreg[WIDTH-1];
  assign word_done = (state == ST_CHECK) && des_rdy;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      grant_id <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= next_state;
      sync_err <= err_set | (sync_err & !err_clr);
      case (state)
        ST_IDLE: begin
          if (found) begin
            shreg    <= req_data[int'(win)*WIDTH +: WIDTH];
            grant_id <= win;
            rr_ptr   <= win;
            bit_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CW'(1);
        end
        ST_CHECK: gap_cnt <= '0;
        ST_GAP:   gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Bench for serdes_tx_sched: a GAP=1 instance with a behavioural deserializer, plus a GAP=0 instance.
module tb_serdes_tx_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0, req_valid_b = '0;
  logic [127:0] req_data;
  logic [3:0]   req_ready, req_ready_b;
  logic         ser_data, ser_val, ser_data_b, ser_val_b;
  logic         des_rdy, des_rdy_b;
  logic [1:0]   grant_id, grant_id_b;
  logic         busy, busy_b, word_done, word_done_b, sync_err, sync_err_b;
  logic         err_clr = 1'b0;
  logic         tie0 = 1'b0, force1 = 1'b0;
  int           cyc = 0;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  int          gid_q[$];
  logic [31:0] req_word[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serdes_tx_sched #(.NUM_REQ(4), .WIDTH(32), .GAP(1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_data(ser_data), .ser_val(ser_val), .des_rdy(des_rdy), .grant_id(grant_id),
    .busy(busy), .word_done(word_done), .sync_err(sync_err), .err_clr(err_clr));

  serdes_tx_sched #(.NUM_REQ(4), .WIDTH(32), .GAP(0), .IDW(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_data(req_data), .req_ready(req_ready_b),
    .ser_data(ser_data_b), .ser_val(ser_val_b), .des_rdy(des_rdy_b), .grant_id(grant_id_b),
    .busy(busy_b), .word_done(word_done_b), .sync_err(sync_err_b), .err_clr(1'b0));

  // Behavioural deserializers: lane 0 on dut, lane 1 on dut_b; tx_rdy follows the 32nd bit.
  logic        rx_v[2], rx_d[2], d_rdy[2];
  logic [31:0] d_sh[2], d_data[2];
  int          d_cnt[2];
  always_comb begin
    rx_v[0] = ser_val;   rx_d[0] = ser_data;
    rx_v[1] = ser_val_b; rx_d[1] = ser_data_b;
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        d_cnt[k] <= 0; d_rdy[k] <= 1'b0; d_sh[k] <= '0; d_data[k] <= '0;
      end else begin
        d_rdy[k] <= 1'b0;
        if (rx_v[k]) begin
          d_sh[k] <= {d_sh[k][30:0], rx_d[k]};
          if (d_cnt[k] == 31) begin
            d_cnt[k] <= 0; d_rdy[k] <= 1'b1; d_data[k] <= {d_sh[k][30:0], rx_d[k]};
          end else d_cnt[k] <= d_cnt[k] + 1;
        end
      end
    end
  end
  assign des_rdy   = (tie0 ? 1'b0 : d_rdy[0]) | force1;
  assign des_rdy_b = d_rdy[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every deserialized word is popped against what was pushed at grant time.
  int run0 = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    int g;
    if (rst) run0 = 0;
    else begin
      if (ser_val) run0++;
      else begin
        check("ser_data_idle", 32'(ser_data), 32'd0);
        if (run0 != 0) begin check("ser_val_len", run0, 32); run0 = 0; end
      end
      if (d_rdy[0]) begin
        if (exp_q.size() == 0) check("unexpected_word", d_data[0], 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front(); g = gid_q.pop_front();
          check("des_word", d_data[0], e);
          check("grant_at_check", 32'(grant_id), g);
        end
      end
    end
  end

  // Call right after a negedge drive; returns at negedge+1 with req_ready nonzero.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (req_ready != 0) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int wd);
    wd = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (word_done) wd++;
      if (!busy) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  // One word: expect requester id to win; optionally pulse a stray strobe at SHIFT bit force_bit.
  task automatic send(input logic [3:0] mask, input int id, input int force_bit, output int wd);
    bit ok;
    wd = 0;
    @(negedge clk);
    req_valid = mask;
    wait_ready(ok);
    if (!ok) return;
    check("grant_onehot", 32'(req_ready), 32'(4'b0001 << id));
    exp_q.push_back(req_word[id]);
    gid_q.push_back(id);
    @(negedge clk);
    req_valid = '0;
    check("ready_pulse", 32'(req_ready), 32'd0);
    req_data[id*32 +: 32] = ~req_word[id];
    if (force_bit >= 0) begin
      repeat (force_bit) @(negedge clk);
      force1 = 1'b1;
      @(negedge clk);
      force1 = 1'b0;
      check("stray_strobe_err", 32'(sync_err), 32'd1);
    end
    wait_idle(wd);
    req_data[id*32 +: 32] = req_word[id];
  endtask

  typedef struct {
    logic [3:0] valid;
    int         grant;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int wd, t_prev, last_acc, nacc, low, ndone;
    bit ok, seen_hi;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wd, t_prev, last_acc, nacc, low, ndone;
    bit ok, seen_hi;
    req_word[0] = 32'hA5A50F0F; req_word[1] = 32'h12345678;
    req_word[2] = 32'hDEADBEEF; req_word[3] = 32'h80000001;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = req_word[i];
    vecs[0]  = '{4'b0001, 0}; vecs[1]  = '{4'b1111, 1}; vecs[2]  = '{4'b1111, 2};
    vecs[3]  = '{4'b1111, 3}; vecs[4]  = '{4'b1111, 0}; vecs[5]  = '{4'b1000, 3};
    vecs[6]  = '{4'b1001, 0}; vecs[7]  = '{4'b0110, 1}; vecs[8]  = '{4'b0101, 2};
    vecs[9]  = '{4'b0001, 0}; vecs[10] = '{4'b1010, 1}; vecs[11] = '{4'b0100, 2};

    // Reset state, including req_ready held low while rst is high.
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_outs", {26'd0, ser_val, ser_data, grant_id, word_done, sync_err, busy},
          32'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;

    // Table-driven single words through the arbiter.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].valid, vecs[i].grant, -1, wd);
      check("word_done_cnt", wd, 1);
      check("sync_err_clean", 32'(sync_err), 32'd0);
    end

    // Strobe never arrives: sticky error, err_clr loses to a simultaneous set.
    tie0 = 1'b1;
    send(4'b0001, 0, -1, wd);
    check("nostrobe_done", wd, 0);
    check("nostrobe_err", 32'(sync_err), 32'd1);
    send(4'b0001, 0, -1, wd);
    check("err_sticky", 32'(sync_err), 32'd1);
    tie0 = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("err_clr", 32'(sync_err), 32'd0);
    err_clr = 1'b1; force1 = 1'b1;
    @(negedge clk); err_clr = 1'b0; force1 = 1'b0;
    check("set_beats_clr", 32'(sync_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("err_clr2", 32'(sync_err), 32'd0);

    // Spurious strobe at SHIFT bit 5; word still completes.
    send(4'b0010, 1, 5, wd);
    check("spurious_done", wd, 1);
    check("spurious_sticky", 32'(sync_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Reset at SHIFT bit 10 after a stray strobe set sync_err.
    req_valid = 4'b1111;
    wait_ready(ok);
    check("pre_reset_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    force1 = 1'b1;
    @(negedge clk);
    force1 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_err", 32'(sync_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {28'd0, ser_val, busy, sync_err, word_done}, 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    exp_q.delete(); gid_q.delete();
    req_valid = 4'b1111;
    @(negedge clk);
    rst = 1'b0;

    // All sources valid continuously: 0,1,2,3,0 at 35-cycle spacing.
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready(ok);
      if (!ok) break;
      check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      exp_q.push_back(req_word[k % 4]);
      gid_q.push_back(k % 4);
      if (k > 0) check("rr_period", cyc - t_prev, 35);
      t_prev = cyc;
      @(negedge clk);
    end
    req_valid = '0;
    wait_idle(wd);
    check("queue_drained", exp_q.size(), 0);

    // GAP=0 instance, requester 2 always valid: 34-cycle period, 2 low cycles between words.
    req_valid_b = 4'b0100;
    last_acc = -1; nacc = 0; low = 0; seen_hi = 1'b0; ndone = 0;
    for (int n = 0; n < 34 * 6 + 20 && nacc < 5; n++) begin
      @(negedge clk);
      if (req_ready_b != 0) begin
        check("gap0_ready", 32'(req_ready_b), 32'b0100);
        if (last_acc >= 0) check("gap0_period", cyc - last_acc, 34);
        last_acc = cyc;
        nacc++;
      end
      if (ser_val_b) begin
        if (seen_hi && low != 0) check("gap0_low", low, 2);
        seen_hi = 1'b1; low = 0;
      end else if (seen_hi) low++;
      if (d_rdy[1]) begin
        check("gap0_word", d_data[1], req_word[2]);
        check("gap0_done", 32'(word_done_b), 32'd1);
        ndone++;
      end
    end
    req_valid_b = '0;
    check("gap0_accepts", nacc, 5);
    check("gap0_words", 32'(ndone > 3), 32'd1);
    check("gap0_grant", 32'(grant_id_b), 32'd2);
    check("gap0_err", 32'(sync_err_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
